// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared types, slave-select constants and address decode for bus_arbiter_ctrl
package bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } bus_state_t;

  localparam logic [2:0] SL_NONE     = 3'b000;
  localparam logic [2:0] SL_S0       = 3'b001;
  localparam logic [2:0] SL_S1       = 3'b010;
  localparam logic [2:0] SL_S2       = 3'b100;
  localparam logic [1:0] SL_UNMAPPED = 2'b11;

  typedef struct packed {
    logic       mapped;
    logic [2:0] sel;
  } sl_dec_t;

  // Takes the top two address bits; the unmapped region yields no select at all.
  function automatic sl_dec_t decode_sl(input logic [1:0] addr_hi);
    sl_dec_t d;
    d.mapped = 1'b1;
    d.sel    = SL_NONE;
    case (addr_hi)
      2'b00:       d.sel = SL_S0;
      2'b01:       d.sel = SL_S1;
      2'b10:       d.sel = SL_S2;
      SL_UNMAPPED: d.mapped = 1'b0;
      default:     d.mapped = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/bus_arbiter_ctrl_rr_arb2.sv
// rtl/bus_arbiter_ctrl_rr_arb2.sv - combinational two-way round-robin grant
// prio_i selects which master wins a tie; a lone requester always wins.
module rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       prio_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o    = 2'b00;
    gnt_o[0] = req_i[0] & (~req_i[1] | ~prio_i);
    gnt_o[1] = req_i[1] & (~req_i[0] |  prio_i);
  end

endmodule

// File: rtl/bus_arbiter_ctrl.sv
// rtl/bus_arbiter_ctrl.sv - two-master System_BUS arbiter and transaction sequencer
// Optional WAIT timeout when BUS_TIMEOUT_EN is defined.
module bus_arbiter_ctrl
  import bus_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 8,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              m0_req,
  input  logic              m1_req,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic              m0_mode,
  input  logic              m1_mode,
  output logic [1:0]        m_grant,
  output logic [1:0]        m_done,
  output logic [DATA_W-1:0] m_rdata,
  output logic              m_err,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] wdata,
  output logic              mode_in,
  output logic              valid,
  output logic [2:0]        sl,
  input  logic              sl_valid,
  input  logic [DATA_W-1:0] sl_rdata
);

  if (TIMEOUT_CYC < 2 || TIMEOUT_CYC > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be within 2..255");
  end

  bus_state_t        state_q;
  logic              prio_q;
  logic [1:0]        grant_q;
  logic [1:0]        done_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;
  logic [ADDR_W-1:0] address_q;
  logic [DATA_W-1:0] wdata_q;
  logic              mode_q;
  logic              valid_q;
  logic [2:0]        sl_q;
`ifdef BUS_TIMEOUT_EN
  logic [7:0]        cnt_q;
`endif

  logic [1:0]        arb_gnt;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_mode;
  sl_dec_t           sel_dec;

  rr_arb2 u_rr_arb2 (
    .req_i  ({m1_req, m0_req}),
    .prio_i (prio_q),
    .gnt_o  (arb_gnt)
  );

  always_comb begin
    sel_addr  = arb_gnt[1] ? m1_addr  : m0_addr;
    sel_wdata = arb_gnt[1] ? m1_wdata : m0_wdata;
    sel_mode  = arb_gnt[1] ? m1_mode  : m0_mode;
    sel_dec   = decode_sl(sel_addr[ADDR_W-1:ADDR_W-2]);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      prio_q    <= 1'b0;
      grant_q   <= 2'b00;
      done_q    <= 2'b00;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      address_q <= '0;
      wdata_q   <= '0;
      mode_q    <= 1'b0;
      valid_q   <= 1'b0;
      sl_q      <= SL_NONE;
`ifdef BUS_TIMEOUT_EN
      cnt_q     <= 8'd0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (m0_req || m1_req) begin
            grant_q <= arb_gnt;
            if (sel_dec.mapped) begin
              address_q <= sel_addr;
              wdata_q   <= sel_wdata;
              mode_q    <= sel_mode;
              sl_q      <= sel_dec.sel;
              valid_q   <= 1'b1;
              state_q   <= ST_ADDR;
`ifdef BUS_TIMEOUT_EN
              cnt_q     <= 8'd0;
`endif
            end else begin
              // Unmapped target completes straight away without touching the bus.
              done_q  <= arb_gnt;
              err_q   <= 1'b1;
              rdata_q <= '0;
              state_q <= ST_DONE;
            end
          end
        end

        ST_ADDR: begin
          valid_q <= 1'b0;
          state_q <= ST_WAIT;
        end

        ST_WAIT: begin
          if (sl_valid) begin
            rdata_q <= mode_q ? '0 : sl_rdata;
            err_q   <= 1'b0;
            done_q  <= grant_q;
            sl_q    <= SL_NONE;
            state_q <= ST_DONE;
          end
`ifdef BUS_TIMEOUT_EN
          else if (cnt_q == 8'(TIMEOUT_CYC - 1)) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
            done_q  <= grant_q;
            sl_q    <= SL_NONE;
            state_q <= ST_DONE;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
`endif
        end

        ST_DONE: begin
          // Priority goes to whichever master was not just served.
          prio_q    <= grant_q[0];
          grant_q   <= 2'b00;
          done_q    <= 2'b00;
          err_q     <= 1'b0;
          address_q <= '0;
          wdata_q   <= '0;
          mode_q    <= 1'b0;
          valid_q   <= 1'b0;
          sl_q      <= SL_NONE;
          state_q   <= ST_IDLE;
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign m_grant = grant_q;
  assign m_done  = done_q;
  assign m_rdata = rdata_q;
  assign m_err   = err_q;
  assign address = address_q;
  assign wdata   = wdata_q;
  assign mode_in = mode_q;
  assign valid   = valid_q;
  assign sl      = sl_q;

endmodule

// File: doc/bus_arbiter_ctrl.md
# bus_arbiter_ctrl

Two-master arbiter and transaction sequencer for the shared System_BUS. It grants the bus round-robin to one of two masters, decodes the target slave from the address, and drives the shared address/data/mode/valid lines plus one-hot slave select toward the slave_bb bridges. It then waits for the selected slave's `sl_valid`/`sl_rdata` response and returns completion, read data and error status to the granted master.

## Interface
- `ADDR_W`, 16, bus address width; slave select is taken from the top 2 bits.
- `DATA_W`, 8, bus data width.
- `TIMEOUT_CYC`, 16, number of WAIT cycles allowed before a timeout error; legal range 2..255. Used only with `BUS_TIMEOUT_EN`.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rstn`  in  1  reset, asynchronous, active-low.
- `m0_req`, `m1_req`  in  1  request from each master; held until the matching `m_done` pulse.
- `m0_addr`, `m1_addr`  in  ADDR_W  transaction address, stable while request is high.
- `m0_wdata`, `m1_wdata`  in  DATA_W  write data.
- `m0_mode`, `m1_mode`  in  1  1 = write, 0 = read.
- `m_grant`  out  2  one-hot grant, high from ADDR through DONE.
- `m_done`  out  2  one-cycle completion pulse to the granted master.
- `m_rdata`  out  DATA_W  read data, valid with `m_done`, held until next DONE.
- `m_err`  out  1  error flag, valid with `m_done`.
- `address`  out  ADDR_W  shared bus address.
- `wdata`  out  DATA_W  shared bus write data.
- `mode_in`  out  1  shared bus mode.
- `valid`  out  1  one-cycle transfer strobe.
- `sl`  out  3  one-hot slave select.
- `sl_valid`  in  1  response strobe from the selected slave, muxed externally.
- `sl_rdata`  in  DATA_W  response data from the selected slave.

## Operation
- States: IDLE, ADDR, WAIT, DONE.
- **IDLE.** All bus outputs are 0.
  - If any request is high: pick a master and latch its addr, wdata and mode.
  - Decode `addr[ADDR_W-1:ADDR_W-2]`: 00→`sl`=001, 01→010, 10→100, 11→unmapped.
  - Mapped address → ADDR. Unmapped → DONE with err=1; `valid` and `sl` are never asserted.
- **Arbitration.** Round-robin with a single priority bit.
  - Reset priority is master 0.
  - When both masters request, the master with priority wins.
  - Priority moves to the other master on every DONE of a granted transaction.
  - A lone requester always wins.
- **ADDR (1 cycle).** `m_grant`, `sl`, `address`, `wdata` and `mode_in` are driven from the latched values, and `valid`=1. Next state is WAIT.
- **WAIT.** `valid`=0; `sl`, `m_grant` and bus lines are held.
  - On `sl_valid`=1: capture `sl_rdata` into `m_rdata` for reads, or 0 for writes; err=0; next state is DONE.
- **DONE (1 cycle).** `m_done[g]`=1 and `m_err` is driven. `sl`=0 and `valid`=0; `m_grant` is still asserted this cycle. Next state is IDLE.
- `sl_valid` outside WAIT is ignored.
- A request deasserted mid-transaction is ignored; the transaction runs to DONE.

## Timing
- All outputs are registered.
- Reset value of every output is 0. Reset also sets state to IDLE and priority to master 0.
- Reset asserted mid-transaction aborts immediately: no `m_done`, `sl` drops asynchronously.
- Latency, with the request sampled at edge N:
  - `valid` and `m_grant` high in cycle N+1.
  - Earliest `sl_valid` is sampled at edge N+2, giving `m_done` in cycle N+3.
  - Unmapped address: `m_done`/`m_err` in cycle N+1.
- Back-to-back: after DONE in cycle D, IDLE is in D+1 and the next grant is in D+2. Minimum 4 cycles per transaction.

## Configuration
- `BUS_TIMEOUT_EN` defined:
  - An 8-bit counter clears on ADDR and increments each WAIT cycle.
  - When the count reaches `TIMEOUT_CYC` without `sl_valid`: go to DONE with `m_err`=1 and `m_rdata`=0.
  - `sl_valid` in the same cycle as expiry wins (normal completion, err=0).
- `BUS_TIMEOUT_EN` undefined: no counter; WAIT lasts indefinitely. `m_err` is set only on unmapped addresses.

## Structure
- Package `bus_pkg`:
  - state enum `bus_state_t`.
  - slave-select constants `SL_S0`/`SL_S1`/`SL_S2`.
  - `SL_UNMAPPED` code 2'b11.
  - function `decode_sl(addr)` returning the one-hot select plus a mapped flag.
- Sub-module `rr_arb2`: two requests plus the priority bit in; one-hot grant out; combinational. The priority register stays in the top level.

## Test plan
- m0 write addr=16'h1234, wdata=8'hAB; slave answers 1 cycle after `valid` → `sl`=001, one `valid` pulse with `address`=1234/`wdata`=AB/`mode_in`=1; `m_done`=01, `m_err`=0.
- m1 read addr=16'h5678, `sl_valid` with `sl_rdata`=8'hCD after 3 WAIT cycles → `sl`=010, `m_done`=10, `m_rdata`=CD.
- Both masters request continuously from reset → grants alternate m0, m1, m0, m1; each transaction is at least 4 cycles apart.
- m0 addr=16'hC000 → `m_done`=01 and `m_err`=1 in the next cycle; `valid` and `sl` stay 0.
- With `BUS_TIMEOUT_EN` and `TIMEOUT_CYC`=16, read to 16'h8000 with no response → `sl`=100, DONE after 16 WAIT cycles, `m_err`=1, `m_rdata`=0. Repeat with `sl_valid` exactly at expiry → `m_err`=0.
- `rstn` pulsed low during WAIT → all outputs 0 immediately; no `m_done`; the next request is granted to m0.
